// File: rtl/aes_sbox_pkg.sv
// Field constants and arithmetic for the composite-field AES S-box.
// GF(2^2) = x^2+x+1, GF(2^4) = y^2+y+PHI, GF(2^8) = z^2+z+LAMBDA.
// Bit matrices are stored row-wise: row i (index [i]) holds the input-bit
// mask whose parity produces output bit i.
package aes_sbox_pkg;

  localparam logic [1:0] PHI       = 2'b10;
  localparam logic [3:0] LAMBDA    = 4'b1100;
  localparam logic [7:0] AFF_C     = 8'h63;
  localparam logic [7:0] INV_AFF_C = 8'h05;

  typedef logic [7:0][7:0] bmat_t;

  // Forward affine: b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7).
  localparam bmat_t AFF = {8'hF8, 8'h7C, 8'h3E, 8'h1F,
                           8'h8F, 8'hC7, 8'hE3, 8'hF1};
  // Inverse affine: a_i = b_(i+2) ^ b_(i+5) ^ b_(i+7).
  localparam bmat_t INV_AFF = {8'h52, 8'h29, 8'h94, 8'h4A,
                               8'h25, 8'h92, 8'h49, 8'hA4};

  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic hh;
    hh = a[1] & b[1];
    return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
  endfunction

  // In GF(2^2) squaring is also inversion (0 maps to 0).
  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, hi, lo;
    hh = gf4_mul(a[3:2], b[3:2]);
    hi = hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]);
    lo = gf4_mul(PHI, hh) ^ gf4_mul(a[1:0], b[1:0]);
    return {hi, lo};
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    logic [1:0] h2;
    h2 = gf4_sq(a[3:2]);
    return {h2, gf4_mul(PHI, h2) ^ gf4_sq(a[1:0])};
  endfunction

  // Same norm/inverse construction one level down; 0 maps to 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] e, ei;
    e  = gf4_mul(PHI, gf4_sq(a[3:2])) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
    ei = gf4_sq(e);
    return {gf4_mul(a[3:2], ei), gf4_mul(a[3:2] ^ a[1:0], ei)};
  endfunction

  // Full composite-field product, only used to derive the basis change.
  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh, hi, lo;
    hh = gf16_mul(a[7:4], b[7:4]);
    hi = hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]);
    lo = gf16_mul(LAMBDA, hh) ^ gf16_mul(a[3:0], b[3:0]);
    return {hi, lo};
  endfunction

  function automatic logic [7:0] mat_mul(input bmat_t m, input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(m[i] & x);
    return r;
  endfunction

  // GF(2) Gauss-Jordan inversion of a non-singular bit matrix.
  function automatic bmat_t mat_inv(input bmat_t m);
    bmat_t      r, e;
    logic [7:0] tr, te;
    int         piv;
    r = m;
    for (int i = 0; i < 8; i++) e[i] = 8'h01 << i;
    for (int col = 0; col < 8; col++) begin
      piv = col;
      for (int i = 7; i >= col; i--) if (r[i][col]) piv = i;
      tr = r[col]; r[col] = r[piv]; r[piv] = tr;
      te = e[col]; e[col] = e[piv]; e[piv] = te;
      for (int i = 0; i < 8; i++) begin
        if (i != col && r[i][col]) begin
          r[i] = r[i] ^ r[col];
          e[i] = e[i] ^ e[col];
        end
      end
    end
    return e;
  endfunction

  // Find a root beta of the AES polynomial X^8+X^4+X^3+X+1 in the composite
  // field; the map X^j -> beta^j is then a field isomorphism, so column j of
  // MAP is beta^j.
  function automatic bmat_t derive_map();
    logic [7:0] beta, c8, p2, p3, p4, p8, col;
    bmat_t      m;
    beta = 8'h00;
    for (int c = 2; c < 256; c++) begin
      c8 = c[7:0];
      p2 = gf256_mul(c8, c8);
      p3 = gf256_mul(p2, c8);
      p4 = gf256_mul(p2, p2);
      p8 = gf256_mul(p4, p4);
      if (beta == 8'h00 && (p8 ^ p4 ^ p3 ^ c8 ^ 8'h01) == 8'h00) beta = c8;
    end
    m   = '0;
    col = 8'h01;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 8; i++) m[i][j] = col[i];
      col = gf256_mul(col, beta);
    end
    return m;
  endfunction

  localparam bmat_t MAP     = derive_map();
  localparam bmat_t MAP_INV = mat_inv(MAP);

endpackage

// File: rtl/aes_sbox_pipe_inv_core.sv
// gf256_inv_core: composite-field GF(2^8) inversion. The first half computes
// the GF(2^4) norm d and its inverse; the second half forms the two output
// multiplies. An optional register between the halves is advanced by the
// parent's stage enable so it behaves as one pipeline stage.
module gf256_inv_core
  import aes_sbox_pkg::*;
#(
  parameter bit REG_MID        = 1'b1,
  parameter bit RST_CLEAR_DATA = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] a,
  output logic [7:0] b
);

  logic [3:0]  ah, al, d, dinv;
  logic [11:0] mid_d, mid_q;

  // Norm d = LAMBDA*ah^2 ^ ah*al ^ al^2 and its inverse, packed with ah/al.
  always_comb begin
    ah    = a[7:4];
    al    = a[3:0];
    d     = gf16_mul(LAMBDA, gf16_sq(ah)) ^ gf16_mul(ah, al) ^ gf16_sq(al);
    dinv  = gf16_inv(d);
    mid_d = {ah, al, dinv};
  end

  generate
    if (REG_MID && RST_CLEAR_DATA) begin : g_mid_clr
      // Mid register, cleared on reset.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  mid_q <= '0;
        else if (en)   mid_q <= mid_d;
      end
    end else if (REG_MID) begin : g_mid_keep
      // Mid register without reset.
      always_ff @(posedge clk) begin
        if (en) mid_q <= mid_d;
      end
    end else begin : g_mid_pass
      assign mid_q = mid_d;
    end
  endgenerate

  // bh = ah*d^-1, bl = (ah^al)*d^-1.
  always_comb begin
    b = {gf16_mul(mid_q[11:8], mid_q[3:0]),
         gf16_mul(mid_q[11:8] ^ mid_q[7:4], mid_q[3:0])};
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: 4-stage AES SubBytes / InvSubBytes with a per-byte mode bit.
// S1 maps into the composite field, S2/S3 invert (gf256_inv_core), S4 maps
// back and applies the forward affine when needed. S4 is the output register.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid, once raised, holds with stable data until accepted. Each stage
// i advances when rdy_i = !v_i | rdy_(i+1) (rdy past S4 is out_ready), so
// bubbles collapse and in_ready is combinational from out_ready.
module aes_sbox_pipe
  import aes_sbox_pkg::*;
#(
  parameter int TAG_W          = 8,
  parameter bit RST_CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [7:0]       in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             inv1;
    logic [7:0]       a1;
    logic [TAG_W-1:0] tag1;
    logic             inv2;
    logic [TAG_W-1:0] tag2;
    logic             inv3;
    logic [7:0]       b3;
    logic [TAG_W-1:0] tag3;
    logic [7:0]       y4;
    logic [TAG_W-1:0] tag4;
  } pipe_t;

  logic       v1, v2, v3, v4;
  logic       rdy1, rdy2, rdy3, rdy4;
  logic       ld1, ld2, ld3, ld4;
  pipe_t      q, d;
  logic [7:0] a_pre, a_next, lin, y_next, core_b;

  assign rdy4      = !v4 | out_ready;
  assign rdy3      = !v3 | rdy4;
  assign rdy2      = !v2 | rdy3;
  assign rdy1      = !v1 | rdy2;
  assign in_ready  = rdy1;
  assign out_valid = v4;
  assign out_data  = q.y4;
  assign out_tag   = q.tag4;

  assign ld1 = rdy1 & in_valid;
  assign ld2 = rdy2 & v1;
  assign ld3 = rdy3 & v2;
  assign ld4 = rdy4 & v3;

  // Stage valids: always reset, shift whenever the stage is ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
    end else begin
      if (rdy1) v1 <= in_valid;
      if (rdy2) v2 <= v1;
      if (rdy3) v3 <= v2;
      if (rdy4) v4 <= v3;
    end
  end

  // S1 input map and S4 output map.
  always_comb begin
    a_pre  = in_inv ? (mat_mul(INV_AFF, in_data) ^ INV_AFF_C) : in_data;
    a_next = mat_mul(MAP, a_pre);
    lin    = mat_mul(MAP_INV, q.b3);
    y_next = q.inv3 ? lin : (mat_mul(AFF, lin) ^ AFF_C);
  end

  gf256_inv_core #(
    .REG_MID        (1'b1),
    .RST_CLEAR_DATA (RST_CLEAR_DATA)
  ) u_inv_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ld2),
    .a       (q.a1),
    .b       (core_b)
  );

  // Next-state of the data registers: each stage loads only on a transfer.
  always_comb begin
    d = q;
    if (ld1) begin
      d.inv1 = in_inv;
      d.a1   = a_next;
      d.tag1 = in_tag;
    end
    if (ld2) begin
      d.inv2 = q.inv1;
      d.tag2 = q.tag1;
    end
    if (ld3) begin
      d.inv3 = q.inv2;
      d.b3   = core_b;
      d.tag3 = q.tag2;
    end
    if (ld4) begin
      d.y4   = y_next;
      d.tag4 = q.tag3;
    end
  end

  generate
    if (RST_CLEAR_DATA) begin : g_data_clr
      // Data registers, cleared on reset.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= d;
      end
    end else begin : g_data_keep
      // Data registers without reset.
      always_ff @(posedge clk) begin
        q <= d;
      end
    end
  endgenerate

endmodule
